clock_display_mux: RTL and testbench

//   Consumes the binary hour/minute outputs of the clock counter and drives a
//   4-digit multiplexed 7-segment display showing HH:MM.
//   - Detects input changes and converts them to BCD with a sequential

---
 rtl/clock_display_mux.sv | 161 ++++++++++++++++
 tb/tb_clock_display_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_mux.sv
// HH:MM front end for a 4-digit multiplexed 7-segment display.
// Binary-to-BCD conversion by repeated subtraction, atomic shadow update, fixed-rate scan.
module clock_display_mux #(
  parameter int REFRESH_DIV = 1000,
  parameter int LZ_BLANK    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minute,
  input  logic [4:0] hour,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy,
  output logic       err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  cap_min;
  logic [4:0]  cap_hour;
  logic [5:0]  work_min;
  logic [4:0]  work_hour;
  logic [2:0]  m_tens;
  logic [1:0]  h_tens;

  // Shadow digits: only ever written together in S_DONE.
  logic [3:0]  dig_m_ones;
  logic [3:0]  dig_m_tens;
  logic [3:0]  dig_h_ones;
  logic [3:0]  dig_h_tens;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    digit_sel;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_min    <= '0;
      cap_hour   <= '0;
      work_min   <= '0;
      work_hour  <= '0;
      m_tens     <= '0;
      h_tens     <= '0;
      dig_m_ones <= '0;
      dig_m_tens <= '0;
      dig_h_ones <= '0;
      dig_h_tens <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Comparing against the captured value means a change that arrived
          // mid-conversion is still picked up here afterwards.
          if ({hour, minute} != {cap_hour, cap_min}) begin
            cap_min   <= minute;
            cap_hour  <= hour;
            work_min  <= minute;
            work_hour <= hour;
            m_tens    <= '0;
            h_tens    <= '0;
            busy      <= 1'b1;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          if (work_min >= 6'd10 || work_hour >= 5'd10) begin
            if (work_min >= 6'd10) begin
              work_min <= work_min - 6'd10;
              m_tens   <= m_tens + 3'd1;
            end
            if (work_hour >= 5'd10) begin
              work_hour <= work_hour - 5'd10;
              h_tens    <= h_tens + 2'd1;
            end
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          dig_m_ones <= work_min[3:0];
          dig_m_tens <= {1'b0, m_tens};
          dig_h_ones <= work_hour[3:0];
          dig_h_tens <= {2'b00, h_tens};
          err        <= (cap_min > 6'd59) || (cap_hour > 5'd23);
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    digit_sel = dig_m_ones;
    case (idx)
      2'd0: digit_sel = dig_m_ones;
      2'd1: digit_sel = dig_m_tens;
      2'd2: digit_sel = dig_h_ones;
      2'd3: digit_sel = dig_h_tens;
      default: digit_sel = dig_m_ones;
    endcase
    if (err)
      seg_next = 7'h40;
    else if ((LZ_BLANK != 0) && (idx == 2'd3) && (dig_h_tens == 4'd0))
      seg_next = 7'h00;
    else
      seg_next = seg_encode(digit_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b0001;
      seg      <= 7'h3F;
      dp       <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      an  <= 4'b0001 << idx;
      seg <= seg_next;
      dp  <= (idx == 2'd2);
    end
  end

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux: arithmetic reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_clock_display_mux;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] minute;
  logic [4:0] hour;

  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic       dp0, dp1, busy0, busy1, err0, err1;

  clock_display_mux #(.REFRESH_DIV(RD), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .minute(minute), .hour(hour),
    .seg(seg0), .an(an0), .dp(dp0), .busy(busy0), .err(err0)
  );

  clock_display_mux #(.REFRESH_DIV(RD), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .minute(minute), .hour(hour),
    .seg(seg1), .an(an1), .dp(dp1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles since reset, captured value, remaining busy cycles,
  // and the value currently shown (as plain integers).
  int          c;
  logic [10:0] cap;
  int          pending;
  int          sh_min, sh_hour;
  bit          m_err;

  logic [6:0] exp_seg0, exp_seg1;
  logic [3:0] exp_an;
  logic       exp_dp, exp_busy, exp_err;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int i, input bit lz);
    int d;
    case (i)
      0:       d = sh_min % 10;
      1:       d = sh_min / 10;
      2:       d = sh_hour % 10;
      default: d = sh_hour / 10;
    endcase
    if (m_err) return 7'h40;
    if (lz && i == 3 && sh_hour / 10 == 0) return 7'h00;
    return seg_tab[d];
  endfunction

  // Advance one clock: derive expectations from the pre-edge model state and
  // the inputs being presented, then compare both DUTs 1 time unit after the edge.
  task automatic tick();
    int oidx, km, kh;
    if (rst) begin
      c = 0; cap = '0; pending = 0; sh_min = 0; sh_hour = 0; m_err = 0;
      exp_an = 4'b0001; exp_seg0 = 7'h3F; exp_seg1 = 7'h3F; exp_dp = 1'b0;
      exp_busy = 1'b0;
    end else begin
      c++;
      oidx     = ((c - 1) / RD) % 4;
      exp_an   = 4'(1 << oidx);
      exp_dp   = (oidx == 2);
      exp_seg0 = model_seg(oidx, 1'b0);
      exp_seg1 = model_seg(oidx, 1'b1);
      if (pending == 0) begin
        if ({hour, minute} != cap) begin
          cap = {hour, minute};
          km = int'(minute) / 10;
          kh = int'(hour) / 10;
          pending = ((km > kh) ? km : kh) + 2;
        end
      end else begin
        pending--;
        if (pending == 0) begin
          sh_min  = int'(cap[5:0]);
          sh_hour = int'(cap[10:6]);
          m_err   = (sh_min > 59) || (sh_hour > 23);
        end
      end
      exp_busy = (pending != 0);
    end
    exp_err = m_err;
    @(posedge clk);
    #1;
    check("an0",   32'(an0),   32'(exp_an));
    check("seg0",  32'(seg0),  32'(exp_seg0));
    check("dp0",   32'(dp0),   32'(exp_dp));
    check("busy0", 32'(busy0), 32'(exp_busy));
    check("err0",  32'(err0),  32'(exp_err));
    check("an1",   32'(an1),   32'(exp_an));
    check("seg1",  32'(seg1),  32'(exp_seg1));
    check("busy1", 32'(busy1), 32'(exp_busy));
    check("err1",  32'(err1),  32'(exp_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick at least once, then until an0 reaches the target; a timeout fails.
  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    tick();
    while (an0 !== target && n < 64) begin
      n++;
      tick();
    end
    if (an0 !== target) check("wait_an_timeout", 32'(an0), 32'(target));
  endtask

  // Apply a value from idle and return how many cycles busy was observed high.
  task automatic apply_and_time(input int h, input int m, output int n);
    hour = 5'(h); minute = 6'(m);
    tick();
    n = 0;
    while (busy0 === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    wait_an(4'b0001); check({tag, "_idx0"}, 32'(seg0), 32'(e0));
    wait_an(4'b0010); check({tag, "_idx1"}, 32'(seg0), 32'(e1));
    wait_an(4'b0100); check({tag, "_idx2"}, 32'(seg0), 32'(e2));
    check({tag, "_dp"}, 32'(dp0), 32'd1);
    wait_an(4'b1000); check({tag, "_idx3"}, 32'(seg0), 32'(e3));
  endtask

  initial begin
    int n;
    rst = 1'b1; hour = '0; minute = '0;
    c = 0; cap = '0; pending = 0; sh_min = 0; sh_hour = 0; m_err = 0;
    ticks(2);
    check("rst_an",   32'(an0),   32'h1);
    check("rst_seg",  32'(seg0),  32'h3F);
    check("rst_busy", 32'(busy0), 32'h0);
    rst = 1'b0;

    // Hold 00:00: scan walks all digits with zeros.
    ticks(20);
    check_digits("zero", 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    apply_and_time(12, 34, n);
    check("busy_len_1234", 32'(n), 32'd5);
    check_digits("d1234", 7'h66, 7'h4F, 7'h5B, 7'h06);
    check("err_1234", 32'(err0), 32'd0);

    apply_and_time(23, 59, n);
    check("busy_len_2359", 32'(n), 32'd7);
    check_digits("d2359", 7'h6F, 7'h6D, 7'h4F, 7'h5B);

    apply_and_time(5, 60, n);
    check("err_set", 32'(err0), 32'd1);
    check_digits("dash", 7'h40, 7'h40, 7'h40, 7'h40);

    // Change mid-conversion: 12:34 latched, then 12:35 picked up afterwards.
    hour = 5'd12; minute = 6'd34;
    tick();
    minute = 6'd35;
    ticks(16);
    check("err_clear", 32'(err0), 32'd0);
    check_digits("d1235", 7'h6D, 7'h4F, 7'h5B, 7'h06);

    // Reset in the middle of converting 23:59.
    hour = 5'd23; minute = 6'd59;
    ticks(3);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_an",   32'(an0),   32'h1);
    check("midrst_seg",  32'(seg0),  32'h3F);
    rst = 1'b0;
    n = 0;
    tick();
    while (busy0 === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check("reconv_len", 32'(n), 32'd7);

    // Leading-zero blanking on the LZ_BLANK=1 instance.
    apply_and_time(5, 7, n);
    wait_an(4'b0100);
    check("lz_idx2", 32'(seg1), 32'h6D);
    wait_an(4'b1000);
    check("lz_idx3", 32'(seg1), 32'h00);
    check("nolz_idx3", 32'(seg0), 32'h3F);

    // Random traffic, mostly legal values, occasional out-of-range and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          minute = 6'($urandom_range(0, 63));
          hour   = 5'($urandom_range(0, 31));
        end else begin
          minute = 6'($urandom_range(0, 59));
          hour   = 5'($urandom_range(0, 23));
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
